// File: rtl/return_stack_pkg.sv
// Shared constants for the return-address stack: branch codes driven to the PC
// and the return target presented while the stack is empty.
package return_stack_pkg;

  localparam logic [2:0] DESVIO_SEQ   = 3'b000;
  localparam logic [2:0] DESVIO_JMP   = 3'b001;
  localparam logic [2:0] DESVIO_BEQ   = 3'b010;
  localparam logic [2:0] DESVIO_RET   = 3'b011;
  localparam logic [2:0] DESVIO_BNE   = 3'b100;
  localparam logic [2:0] DESVIO_BLT   = 3'b101;
  localparam logic [2:0] DESVIO_BGE   = 3'b110;

  // Wide enough for any practical address width; sliced down to WIDTH at use.
  localparam logic [63:0] RESET_VECTOR = '1;

endpackage

// File: rtl/return_stack_if.sv
// PC-side bus of the return stack: push/pop requests in, top-of-stack and status out.
interface return_stack_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
);

  logic                     stop;
  logic                     call;
  logic [2:0]               desvio;
  logic [WIDTH-1:0]         endereco;
  logic [WIDTH-1:0]         novoEndR;
  logic                     empty;
  logic                     full;
  logic                     overflow;
  logic                     underflow;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output stop, call, desvio, endereco,
    input  novoEndR, empty, full, overflow, underflow, count
  );

  modport slave (
    input  stop, call, desvio, endereco,
    output novoEndR, empty, full, overflow, underflow, count
  );

endinterface

// File: rtl/return_stack_regfile.sv
// Entry storage for the return stack: one write port, one asynchronous read port,
// deliberately not reset so stale entries simply become unreachable.
module rs_regfile #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_stack.sv
// Circular return-address stack: pushes link addresses on call, pops on return,
// and presents the top entry combinationally so the PC can take it on the pop edge.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  return_stack_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    r_sp;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_replace;
  logic [AW-1:0]    w_sp_m1;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rdata;

  assign w_push    = bus.call & ~bus.stop;
  assign w_pop     = (bus.desvio == DESVIO_RET) & ~bus.stop;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_sp_m1   = r_sp - 1'b1;
  // A simultaneous call/return replaces the top in place; on an empty stack it is a plain push.
  assign w_replace = w_push & w_pop & ~w_empty;
  assign w_waddr   = w_replace ? w_sp_m1 : r_sp;
  assign w_wdata   = bus.endereco + 1'b1;

  rs_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clock   (clock),
    .i_we    (w_push & reset),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_sp_m1),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_replace) begin
      r_sp    <= r_sp;
      r_count <= r_count;
    end else if (w_push) begin
      r_sp <= r_sp + 1'b1;
      if (w_full) r_overflow <= 1'b1;
      else        r_count    <= r_count + 1'b1;
    end else if (w_pop) begin
      if (w_empty) begin
        r_underflow <= 1'b1;
      end else begin
        r_sp    <= w_sp_m1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign bus.novoEndR  = w_empty ? RESET_VECTOR[WIDTH-1:0] : w_rdata;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack (DEPTH=8, WIDTH=32) with hand-computed expectations.
module tb_return_stack;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  return_stack_if #(.DEPTH(8), .WIDTH(32)) rs_bus ();

  return_stack #(.DEPTH(8), .WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rs_bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] addr);
    rs_bus.call     = 1'b1;
    rs_bus.endereco = addr;
    step();
    rs_bus.call     = 1'b0;
  endtask

  task automatic pop();
    rs_bus.desvio = 3'b011;
    step();
    rs_bus.desvio = 3'b000;
  endtask

  task automatic check_state(input string tag, input int cnt, input logic [31:0] top,
                             input logic ovf, input logic unf);
    check({tag, ".count"}, 64'(rs_bus.count), 64'(cnt));
    check({tag, ".top"},   64'(rs_bus.novoEndR), 64'(top));
    check({tag, ".empty"}, 64'(rs_bus.empty), 64'(cnt == 0));
    check({tag, ".full"},  64'(rs_bus.full),  64'(cnt == 8));
    check({tag, ".ovf"},   64'(rs_bus.overflow), 64'(ovf));
    check({tag, ".unf"},   64'(rs_bus.underflow), 64'(unf));
  endtask

  initial begin
    rs_bus.stop     = 1'b0;
    rs_bus.call     = 1'b0;
    rs_bus.desvio   = 3'b000;
    rs_bus.endereco = '0;
    step();
    step();
    reset = 1'b1;
    check_state("reset", 0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // single push, then two more; pops expose tops on the pop cycles
    push(32'h10);
    check_state("push1", 1, 32'h11, 1'b0, 1'b0);
    push(32'h20);
    push(32'h30);
    check_state("push3", 3, 32'h31, 1'b0, 1'b0);
    rs_bus.desvio = 3'b011;
    check("pop_a.top", 64'(rs_bus.novoEndR), 64'h31);
    step();
    check("pop_b.top", 64'(rs_bus.novoEndR), 64'h21);
    step();
    check("pop_c.top", 64'(rs_bus.novoEndR), 64'h11);
    step();
    rs_bus.desvio = 3'b000;
    check_state("drained", 0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // non-return branch codes leave the stack alone
    push(32'h50);
    for (int c = 0; c < 8; c++) begin
      if (c != 3) begin
        rs_bus.desvio = 3'(c);
        step();
      end
    end
    rs_bus.desvio = 3'b000;
    check_state("codes", 1, 32'h51, 1'b0, 1'b0);
    pop();

    // fill, then one push past full overwrites the oldest entry
    for (int i = 0; i < 8; i++) push(32'(i));
    check_state("fill8", 8, 32'h8, 1'b0, 1'b0);
    push(32'h8);
    check_state("fill9", 8, 32'h9, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rs_bus.desvio = 3'b011;
      check($sformatf("ovpop%0d", i), 64'(rs_bus.novoEndR), 64'(9 - i));
      step();
    end
    rs_bus.desvio = 3'b000;
    check_state("ovdrain", 0, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // call+return on empty stack acts as push without underflow
    rs_bus.call = 1'b1; rs_bus.desvio = 3'b011; rs_bus.endereco = 32'h70;
    step();
    rs_bus.call = 1'b0; rs_bus.desvio = 3'b000;
    check_state("pp_empty", 1, 32'h71, 1'b1, 1'b0);
    pop();
    pop();
    check_state("underflow", 0, 32'hFFFF_FFFF, 1'b1, 1'b1);

    // call+return on non-empty stack replaces the top
    push(32'h10);
    rs_bus.call = 1'b1; rs_bus.desvio = 3'b011; rs_bus.endereco = 32'h40;
    step();
    rs_bus.call = 1'b0; rs_bus.desvio = 3'b000;
    check_state("replace", 1, 32'h41, 1'b1, 1'b1);

    // stop freezes everything
    push(32'hA0);
    push(32'hB0);
    push(32'hC0);
    rs_bus.stop = 1'b1; rs_bus.call = 1'b1; rs_bus.desvio = 3'b011; rs_bus.endereco = 32'h99;
    repeat (3) step();
    rs_bus.stop = 1'b0; rs_bus.call = 1'b0; rs_bus.desvio = 3'b000;
    check_state("stop", 4, 32'hC1, 1'b1, 1'b1);
    pop();
    check_state("after_stop", 3, 32'hB1, 1'b1, 1'b1);

    // reset wins over a concurrent push and discards everything
    push(32'hD0);
    reset = 1'b0; rs_bus.call = 1'b1; rs_bus.endereco = 32'hE0;
    step();
    reset = 1'b1; rs_bus.call = 1'b0;
    check_state("midreset", 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    push(32'h5);
    check_state("post_reset_push", 1, 32'h6, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of return-address entries; power of two, at least 2.
REQ-002 Parameter WIDTH, default 32, address width in bits.
REQ-003 clock  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 stop  input  1  processor halt; when 1, no push or pop takes effect.
REQ-006 call  input  1  current instruction is jump-and-link; requests a push.
REQ-007 desvio  input  3  branch code driven to the PC; 3'b011 (return) requests a pop.
REQ-008 endereco  input  WIDTH  current PC value.
REQ-009 novoEndR  output  WIDTH  return target (top of stack), consumed by the PC.
REQ-010 empty  output  1  stack holds zero entries.
REQ-011 full  output  1  stack holds DEPTH entries.
REQ-012 overflow  output  1  sticky; a push occurred while full.
REQ-013 underflow  output  1  sticky; a pop occurred while empty.
REQ-014 count  output  $clog2(DEPTH)+1  current number of valid entries.

Function
REQ-015 push_req = call & !stop; pop_req = (desvio == 3'b011) & !stop.
REQ-016 novoEndR SHALL be combinational from registered state: the entry at sp-1 when count>0, else all-ones (WIDTH'hFFFF_FFFF), so the PC samples it on the same edge the pop takes effect.
REQ-017 Push only: write endereco+1 (modulo 2^WIDTH) at sp; sp increments mod DEPTH; count increments; new top visible the cycle after the edge.
REQ-018 Pop only: sp decrements mod DEPTH; count decrements; entry contents unchanged.
REQ-019 Push and pop in the same cycle: overwrite entry at sp-1 with endereco+1; sp and count unchanged; if empty, behave as push only, and underflow is not set.
REQ-020 Push while full (no pop): circular overwrite of oldest entry; sp increments mod DEPTH; count stays DEPTH; overflow sets.
REQ-021 Pop while empty (no push): sp and count unchanged; underflow sets; novoEndR stays all-ones.
REQ-022 overflow and underflow SHALL clear only on reset.
REQ-023 full = (count == DEPTH); empty = (count == 0); both combinational from count.
REQ-024 stop=1 SHALL freeze sp, count, entries and flags regardless of call/desvio.
REQ-025 desvio codes other than 3'b011 SHALL have no effect on the stack.

Reset
REQ-026 When reset=0 at a rising edge: sp=0, count=0, overflow=0, underflow=0; reset has priority over stop, push and pop.
REQ-027 Entry storage SHALL NOT be cleared by reset; novoEndR reads all-ones after reset via the empty rule.
REQ-028 Reset asserted mid-sequence SHALL discard all pending entries on that edge.

Structure
REQ-029 Shared package holds: desvio code constants (DESVIO_SEQ=3'b000, DESVIO_JMP=3'b001, DESVIO_RET=3'b011, conditional codes 3'b010/100/101/110) and RESET_VECTOR = all-ones.
REQ-030 Entry storage SHALL be one sub-module, rs_regfile (DEPTH x WIDTH, one write port, one asynchronous read port, no reset).
REQ-031 Pointer/count/flag logic lives in return_stack; no other sub-modules.

Verification
REQ-032 Reset, then call=1 with endereco=0x10 for one cycle -> next cycle novoEndR=0x11, count=1, empty=0.
REQ-033 Pushes 0x10, 0x20, 0x30, then three cycles with desvio=011 -> novoEndR reads 0x31, 0x21, 0x11 on the pop cycles, then empty=1 and novoEndR=0xFFFFFFFF.
REQ-034 DEPTH=8: nine pushes with endereco=0..8 -> full=1, overflow=1, count=8; eight pops yield 9,8,...,2.
REQ-035 Empty, desvio=011 -> underflow=1, count=0; call=1 and desvio=011 together with endereco=0x40 on a stack with top 0x11 -> top becomes 0x41, count unchanged.
REQ-036 stop=1 with call=1 and desvio=011 for 3 cycles -> no state change; reset=0 with 4 entries and both flags set -> next cycle count=0, flags=0, novoEndR=0xFFFFFFFF.
